// File: rtl/vga_pkg.sv
// Shared framebuffer constants and types for the VGA device and its drawing engines.
package vga_pkg;

    localparam int unsigned FB_WIDTH         = 160;
    localparam int unsigned FB_HEIGHT        = 120;
    localparam int unsigned FB_PIXELS        = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned FB_ADDRESS_WIDTH = $clog2(FB_PIXELS);
    localparam int unsigned FB_DATA_WIDTH    = 8;

    typedef logic [FB_ADDRESS_WIDTH-1:0] fb_addr_t;
    typedef logic [FB_DATA_WIDTH-1:0]    color_index_t;

    typedef struct packed {
        logic [7:0]   x;
        logic [7:0]   y;
        logic [7:0]   w;
        logic [7:0]   h;
        color_index_t color;
    } rect_cmd_t;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_SETUP,
        FILL_RUN,
        FILL_DONE
    } fill_state_t;

endpackage

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: clips a command to the framebuffer and streams one
// pixel write per unstalled cycle into the back-buffer write port.
module vga_rect_fill
    import vga_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [7:0]   cmd_x,
    input  logic [7:0]   cmd_y,
    input  logic [7:0]   cmd_w,
    input  logic [7:0]   cmd_h,
    input  color_index_t cmd_color,
    input  logic         fb_stall,
    output logic         fb_wren,
    output fb_addr_t     fb_address,
    output color_index_t fb_data,
    output logic         busy,
    output logic         done
);

    localparam logic [8:0] WIDTH9  = 9'(FB_WIDTH);
    localparam logic [8:0] HEIGHT9 = 9'(FB_HEIGHT);

    fill_state_t state, state_next;
    rect_cmd_t   cmd;
    logic [8:0]  xe, ye;
    logic [7:0]  cx, cy;
    fb_addr_t    row_base;

    logic [8:0] x_end, y_end;
    logic       empty, x_last, y_last;

    // 9-bit sums so x+w and y+h never wrap before clipping.
    assign x_end  = {1'b0, cmd.x} + {1'b0, cmd.w};
    assign y_end  = {1'b0, cmd.y} + {1'b0, cmd.h};
    assign empty  = (cmd.w == '0) || (cmd.h == '0) ||
                    ({1'b0, cmd.x} >= WIDTH9) || ({1'b0, cmd.y} >= HEIGHT9);
    assign x_last = ({1'b0, cx} + 9'd1) >= xe;
    assign y_last = ({1'b0, cy} + 9'd1) >= ye;

    assign fb_address = row_base + fb_addr_t'(cx);
    assign fb_data    = cmd.color;

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        fb_wren    = 1'b0;
        case (state)
            FILL_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_next = FILL_SETUP;
            end
            FILL_SETUP: state_next = empty ? FILL_DONE : FILL_RUN;
            FILL_RUN: begin
                fb_wren = !fb_stall;
                if (!fb_stall && x_last && y_last) state_next = FILL_DONE;
            end
            FILL_DONE: begin
                done       = 1'b1;
                state_next = FILL_IDLE;
            end
            default: state_next = FILL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FILL_IDLE;
            cmd      <= '0;
            xe       <= '0;
            ye       <= '0;
            cx       <= '0;
            cy       <= '0;
            row_base <= '0;
        end else begin
            state <= state_next;
            case (state)
                FILL_IDLE: begin
                    if (cmd_valid) begin
                        cmd <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};
                    end
                end
                FILL_SETUP: begin
                    xe       <= (x_end > WIDTH9)  ? WIDTH9  : x_end;
                    ye       <= (y_end > HEIGHT9) ? HEIGHT9 : y_end;
                    cx       <= cmd.x;
                    cy       <= cmd.y;
                    // y*160 as y*128 + y*32
                    row_base <= (fb_addr_t'(cmd.y) << 7) + (fb_addr_t'(cmd.y) << 5);
                end
                FILL_RUN: begin
                    if (fb_wren) begin
                        if (!x_last) begin
                            cx <= cx + 8'd1;
                        end else if (!y_last) begin
                            cx       <= cmd.x;
                            cy       <= cy + 8'd1;
                            row_base <= row_base + fb_addr_t'(FB_WIDTH);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Scoreboard bench for vga_rect_fill: a pixel-list reference model feeds a queue
// that a negedge monitor drains against the write port.
module tb_vga_rect_fill;
    import vga_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [7:0]   cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    color_index_t cmd_color = '0;
    logic         fb_stall = 1'b0;
    logic         fb_wren;
    fb_addr_t     fb_address;
    color_index_t fb_data;
    logic         busy;
    logic         done;

    vga_rect_fill dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .fb_stall  (fb_stall),
        .fb_wren   (fb_wren),
        .fb_address(fb_address),
        .fb_data   (fb_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        bit          empty;
        int unsigned addr;
        int unsigned data;
    } exp_t;

    exp_t        q[$];
    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    bit          mon_en     = 0;
    bit          active     = 0;
    bit          done_seen  = 0;
    int unsigned accept_cyc = 0;
    int unsigned last_write_cyc = 0;
    int unsigned n_writes   = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: every pixel of the requested rectangle that lies on screen, in raster order.
    task automatic push_model(input int unsigned x, input int unsigned y, input int unsigned w,
                              input int unsigned h, input int unsigned color, output int unsigned n);
        n = 0;
        for (int unsigned yy = y; yy < y + h; yy++) begin
            for (int unsigned xx = x; xx < x + w; xx++) begin
                if (xx < FB_WIDTH && yy < FB_HEIGHT) begin
                    q.push_back('{is_done: 1'b0, empty: 1'b0, addr: yy * FB_WIDTH + xx, data: color});
                    n++;
                end
            end
        end
        q.push_back('{is_done: 1'b1, empty: (n == 0), addr: 0, data: 0});
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            automatic bit   exp_busy = active && (cyc >= accept_cyc + 1);
            automatic exp_t it;
            check("busy", busy, exp_busy);
            check("cmd_ready", cmd_ready, !exp_busy);
            if (fb_wren) begin
                if (q.size() == 0 || q[0].is_done) begin
                    check("spurious_write", fb_wren, 0);
                end else begin
                    it = q.pop_front();
                    check("fb_address", fb_address, it.addr);
                    check("fb_data", fb_data, it.data);
                    check("wren_during_stall", fb_stall, 0);
                    last_write_cyc = cyc;
                    n_writes++;
                end
            end else if (active && cyc >= accept_cyc + 2 && !done && q.size() != 0 && !q[0].is_done) begin
                if (!fb_stall) check("write_bubble", fb_wren, 1);
                else           check("stall_hold_address", fb_address, q[0].addr);
            end
            if (done) begin
                if (q.size() == 0 || !q[0].is_done) begin
                    check("spurious_done", done, 0);
                end else begin
                    it = q.pop_front();
                    check("done_cycle", cyc, it.empty ? accept_cyc + 2 : last_write_cyc + 1);
                    done_seen = 1;
                    active    = 0;
                end
            end
        end
    end

    // stall_mode: 0 none, 1 random, 2 stall on T+3 and T+4. rst_at: write index to reset on (0 = never).
    task automatic run_cmd(input int unsigned x, input int unsigned y, input int unsigned w,
                           input int unsigned h, input int unsigned color, input int unsigned stall_mode,
                           input bit poke_busy, input int unsigned rst_at);
        int unsigned n, budget, start_w;
        budget = 0;
        while (!cmd_ready && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        cmd_x = 8'(x); cmd_y = 8'(y); cmd_w = 8'(w); cmd_h = 8'(h); cmd_color = color_index_t'(color);
        cmd_valid  = 1'b1;
        fb_stall   = 1'b0;
        done_seen  = 0;
        start_w    = n_writes;
        push_model(x, y, w, h, color, n);
        accept_cyc = cyc;
        active     = 1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_x = 8'($urandom); cmd_y = 8'($urandom); cmd_w = 8'($urandom); cmd_h = 8'($urandom);
        cmd_color = color_index_t'($urandom);
        budget = 0;
        while (!done_seen && budget < n * 4 + 50) begin
            case (stall_mode)
                1:       fb_stall = ($urandom_range(0, 3) == 0);
                2:       fb_stall = (cyc == accept_cyc + 3) || (cyc == accept_cyc + 4);
                default: fb_stall = 1'b0;
            endcase
            if (poke_busy) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_x = 8'($urandom); cmd_y = 8'($urandom); cmd_w = 8'($urandom); cmd_h = 8'($urandom);
            end
            if (rst_at != 0 && cyc >= accept_cyc + 2 && n_writes - start_w == rst_at - 1) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                q.delete();
                active    = 0;
                cmd_valid = 1'b0;
                fb_stall  = 1'b0;
                check("writes_before_rst", n_writes - start_w, rst_at);
                check("ready_after_rst", cmd_ready, 1);
                check("wren_after_rst", fb_wren, 0);
                check("done_after_rst", done, 0);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            budget++;
        end
        cmd_valid = 1'b0;
        fb_stall  = 1'b0;
        check("done_seen", done_seen, 1);
        check("write_count", n_writes - start_w, n);
    endtask

    initial begin
        #900000;
        mismatched++;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_fb_wren", fb_wren, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fb_address", fb_address, 0);
        check("rst_fb_data", fb_data, 0);
        rst    = 1'b0;
        mon_en = 1;
        @(posedge clk); #1;

        run_cmd(2, 3, 4, 2, 8'h2A, 0, 0, 0);
        run_cmd(158, 119, 10, 5, 8'h07, 0, 0, 0);
        run_cmd(10, 10, 0, 5, 8'h11, 0, 0, 0);
        run_cmd(160, 10, 5, 5, 8'h12, 0, 0, 0);
        run_cmd(0, 0, 3, 1, 8'h33, 2, 0, 0);
        run_cmd(0, 0, 160, 120, 8'h44, 0, 0, 100);
        run_cmd(5, 6, 7, 3, 8'h55, 0, 0, 0);
        run_cmd(0, 0, 160, 120, 8'h66, 1, 1, 0);

        for (int i = 0; i < 30; i++) begin
            run_cmd($urandom_range(0, 175), $urandom_range(0, 135),
                    ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24),
                    $urandom_range(0, 24), $urandom_range(0, 255), 1, 0, 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
